morse_sos_detector: RTL and testbench

- Receive side of the buzzer SOS link: samples an active-low keyed line (buzzer drive or key button) and times every mark and space in 1 ms ticks.
- Classifies each mark as dot (short) or dash (long) and reports every symbol.
- Asserts a one-cycle SOS_Found pulse when the sequence S S S L L L S S S (… --- …) arrives with inter-mark spaces below the gap timeout.
- Timing matches the SOS generator: 100 ms dot, 300 ms dash, 50 ms interval, 50 MHz clock.

---
 rtl/morse_sos_detector.sv | 105 ++++++++++
 tb/tb_morse_sos_detector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/morse_sos_detector.sv
// morse_sos_detector: times marks/spaces on an active-low keyed line, classifies dots and dashes
// and pulses SOS_Found when S S S L L L S S S arrives without a gap timeout.
module morse_sos_detector #(
   parameter logic [15:0] T1MS        = 16'd49_999,
   parameter logic [9:0]  SHORT_MIN   = 10'd60,
   parameter logic [9:0]  SHORT_MAX   = 10'd180,
   parameter logic [9:0]  LONG_MIN    = 10'd200,
   parameter logic [9:0]  LONG_MAX    = 10'd450,
   parameter logic [9:0]  GAP_TIMEOUT = 10'd500
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic Det_En,
   input  logic Pin_In,
   output logic Sym_Valid,
   output logic Sym_Long,
   output logic SOS_Found,
   output logic Err,
   output logic Busy
);
   typedef enum logic [1:0] {IDLE, MARK, WAIT_REL, SPACE} state_t;
   state_t state, state_nx;
   logic [1:0]  sync;
   logic [15:0] clk_cnt;
   logic [9:0]  ms, ms_inc, ms_eff;
   logic [3:0]  idx, idx_nx;
   logic mark, wrap, counting, is_dot, is_dash, too_long, want_long, match;
   logic sym_valid_nx, sym_long_nx, sos_nx, err_nx;

   assign mark      = !sync[1];
   assign wrap      = clk_cnt == T1MS;
   assign counting  = state == MARK || state == SPACE;
   assign ms_inc    = (ms == 10'd1023) ? ms : ms + 10'd1;
   // length including the millisecond that completes on this very edge
   assign ms_eff    = wrap ? ms_inc : ms;
   assign is_dot    = ms_eff >= SHORT_MIN && ms_eff <= SHORT_MAX;
   assign is_dash   = ms_eff >= LONG_MIN && ms_eff <= LONG_MAX;
   assign too_long  = ms_eff > LONG_MAX;
   assign want_long = idx >= 4'd3 && idx <= 4'd5;
   assign match     = is_dash == want_long;

   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) sync <= 2'b11;
      else       sync <= {sync[0], Pin_In};

   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) begin
         state     <= IDLE;
         idx       <= '0;
         clk_cnt   <= '0;
         ms        <= '0;
         Sym_Valid <= 1'b0;
         Sym_Long  <= 1'b0;
         SOS_Found <= 1'b0;
         Err       <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         clk_cnt   <= (state_nx != state || !counting || wrap) ? '0 : clk_cnt + 16'd1;
         ms        <= (state_nx != state || !counting) ? '0 : wrap ? ms_inc : ms;
         Sym_Valid <= sym_valid_nx;
         Sym_Long  <= sym_long_nx;
         SOS_Found <= sos_nx;
         Err       <= err_nx;
         Busy      <= state_nx != IDLE;
      end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      if (!Det_En) begin
         state_nx = IDLE;
         idx_nx   = '0;
      end else
         case (state)
            IDLE:     state_nx = mark ? MARK : IDLE;
            MARK:
               if (mark && too_long) begin
                  state_nx = WAIT_REL;
                  idx_nx   = '0;
               end else if (!mark) begin
                  state_nx = SPACE;
                  idx_nx   = !(is_dot || is_dash) ? 4'd0 :
                             match ? ((idx == 4'd8) ? 4'd0 : idx + 4'd1) :
                             is_dash ? 4'd0 : (idx == 4'd3) ? 4'd3 : 4'd1;
               end
            WAIT_REL: state_nx = mark ? WAIT_REL : SPACE;
            SPACE:
               if (mark) state_nx = MARK;
               else if (ms == GAP_TIMEOUT) begin
                  state_nx = IDLE;
                  idx_nx   = '0;
               end
            default:  state_nx = IDLE;
         endcase
   end

   always_comb begin
      sym_valid_nx = Det_En && state == MARK && !mark && (is_dot || is_dash);
      err_nx       = Det_En && state == MARK && (mark ? too_long : !(is_dot || is_dash));
      sym_long_nx  = sym_valid_nx ? is_dash : Sym_Long;
      sos_nx       = sym_valid_nx && match && idx == 4'd8;
   end
endmodule

// File: tb/tb_morse_sos_detector.sv
// tb_morse_sos_detector: directed Morse traffic against morse_sos_detector with a short ms tick
// so the whole run stays small; durations below are in ms.
module tb_morse_sos_detector;
   localparam int CPM = 2;
   logic CLK = 1'b0, RSTn = 1'b0, Det_En = 1'b1, Pin_In = 1'b1;
   logic Sym_Valid, Sym_Long, SOS_Found, Err, Busy;
   int n_cmp = 0, n_bad = 0, cyc = 0, mark_cyc = 0;
   int err_cyc = 0, sos_cnt = 0, sos_at = 0, viol = 0;
   string ev = "";
   int durs[7] = '{59, 60, 180, 181, 199, 200, 450};
   int b, s;

   morse_sos_detector #(.T1MS(16'(CPM - 1))) dut (
      .CLK(CLK), .RSTn(RSTn), .Det_En(Det_En), .Pin_In(Pin_In),
      .Sym_Valid(Sym_Valid), .Sym_Long(Sym_Long), .SOS_Found(SOS_Found),
      .Err(Err), .Busy(Busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // event log: S dot, L dash, E error; sampled mid-cycle
   always @(negedge CLK) begin
      if (Sym_Valid && Sym_Long) ev <= {ev, "L"};
      else if (Sym_Valid)        ev <= {ev, "S"};
      else if (Err)              ev <= {ev, "E"};
      if (Err) err_cyc <= cyc;
      if (SOS_Found) begin
         sos_cnt <= sos_cnt + 1;
         sos_at  <= ev.len() + 1;
      end
      if ((SOS_Found && !Sym_Valid) || (Err && Sym_Valid)) viol <= viol + 1;
   end

   task automatic check(string tag, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic mk(int ms);
      Pin_In   = 1'b0;
      mark_cyc = cyc;
      tick(ms * CPM);
      Pin_In   = 1'b1;
   endtask

   task automatic sp(int ms);
      tick(ms * CPM);
   endtask

   task automatic send(string str);
      for (int i = 0; i < str.len(); i++) begin
         mk(str[i] == "L" ? 300 : 100);
         sp(50);
      end
   endtask

   task automatic check_seq(string tag, int base, string exp);
      string got;
      got = ev.substr(base, ev.len() - 1);
      check({tag, " len"}, got.len(), exp.len());
      for (int i = 0; i < got.len() && i < exp.len(); i++)
         check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
   endtask

   task automatic check_outs(string tag);
      check({tag, " Sym_Valid"}, Sym_Valid, 0);
      check({tag, " Sym_Long"}, Sym_Long, 0);
      check({tag, " SOS_Found"}, SOS_Found, 0);
      check({tag, " Err"}, Err, 0);
      check({tag, " Busy"}, Busy, 0);
   endtask

   initial begin
      tick(5);
      check_outs("reset");
      RSTn = 1'b1;
      tick(5);

      b = ev.len(); s = sos_cnt;
      send("SSSLLLSSS");
      check_seq("t1 seq", b, "SSSLLLSSS");
      check("t1 sos count", sos_cnt - s, 1);
      check("t1 sos on 9th", sos_at - b, 9);
      check("t1 busy in space", Busy, 1);
      sp(520);
      check("t1 busy after gap", Busy, 0);

      b = ev.len(); s = sos_cnt;
      send("SSSSLLLSSS");
      check_seq("t2 seq", b, "SSSSLLLSSS");
      check("t2 sos count", sos_cnt - s, 1);
      check("t2 sos on 10th", sos_at - b, 10);
      sp(520);

      b = ev.len(); s = sos_cnt;
      foreach (durs[i]) begin
         mk(durs[i]);
         sp(50);
      end
      check_seq("t3 seq", b, "ESSEELL");
      check("t3 sos count", sos_cnt - s, 0);
      sp(520);

      // 2 sync flops + entry edge, then Err on the edge completing ms 451
      b = ev.len(); s = sos_cnt;
      mk(600);
      check("t4 err timing", err_cyc - mark_cyc, 3 + CPM * 451);
      sp(50);
      send("SSSLLLSSS");
      check_seq("t4 seq", b, "ESSSLLLSSS");
      check("t4 sos count", sos_cnt - s, 1);
      sp(520);

      b = ev.len(); s = sos_cnt;
      send("SSSL");
      sp(520);
      check("t5 busy after gap", Busy, 0);
      send("LLSSS");
      check_seq("t5 seq", b, "SSSLLLSSS");
      check("t5 sos count", sos_cnt - s, 0);
      sp(520);

      b = ev.len(); s = sos_cnt;
      send("SSSLL");
      RSTn = 1'b0;
      tick(3);
      check_outs("t6 in reset");
      RSTn = 1'b1;
      tick(2);
      send("LSSS");
      check_seq("t6a seq", b, "SSSLLLSSS");
      check("t6a sos count", sos_cnt - s, 0);
      sp(520);

      b = ev.len(); s = sos_cnt;
      send("SSSLLLSS");
      Pin_In = 1'b0;
      sp(50);
      Det_En = 1'b0;
      tick(4);
      check_outs("t6 enable low");
      sp(50);
      Pin_In = 1'b1;
      sp(50);
      Det_En = 1'b1;
      sp(10);
      send("S");
      check("t6b no sos yet", sos_cnt - s, 0);
      send("SSSLLLSSS");
      check_seq("t6b seq", b, "SSSLLLSSSSSSLLLSSS");
      check("t6b sos count", sos_cnt - s, 1);
      check("t6b sos on 18th", sos_at - b, 18);
      sp(520);
      check("t6b busy after gap", Busy, 0);

      check("pulse exclusivity", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
